// File: rtl/isa_pkg.sv
// ISA constants shared by the decode stage: opcodes, ALU operation codes and
// instruction field positions for the 24-bit instruction format.
package isa_pkg;

    localparam int OPCODE_MSB = 23;
    localparam int OPCODE_LSB = 20;
    localparam int RD_MSB     = 19;
    localparam int RD_LSB     = 16;
    localparam int RS1_MSB    = 15;
    localparam int RS1_LSB    = 12;
    localparam int RS2_MSB    = 11;
    localparam int RS2_LSB    = 8;
    localparam int IMM12_MSB  = 11;
    localparam int IMM20_MSB  = 19;

    typedef enum logic [3:0] {
        OP_NOP   = 4'h0,
        OP_ADD   = 4'h1,
        OP_SUB   = 4'h2,
        OP_MUL   = 4'h3,
        OP_AND   = 4'h4,
        OP_OR    = 4'h5,
        OP_ADDI  = 4'h6,
        OP_SHLI  = 4'h7,
        OP_SHRI  = 4'h8,
        OP_LOAD  = 4'h9,
        OP_STORE = 4'hA,
        OP_CMP   = 4'hB,
        OP_BEQ   = 4'hC,
        OP_BNE   = 4'hD,
        OP_B     = 4'hE,
        OP_END   = 4'hF
    } opcode_e;

    typedef enum logic [2:0] {
        ALU_ADD   = 3'b000,
        ALU_SUB   = 3'b001,
        ALU_MUL   = 3'b010,
        ALU_AND   = 3'b011,
        ALU_OR    = 3'b100,
        ALU_SHL   = 3'b101,
        ALU_SHR   = 3'b110,
        ALU_PASSB = 3'b111
    } alu_op_e;

    function automatic logic isBranchOp(input logic [3:0] op);
        return (op == OP_BEQ) || (op == OP_BNE) || (op == OP_B);
    endfunction

endpackage

// File: rtl/register_file.sv
// Two-read, one-write register file with write-first bypass: a read of the
// register being written this cycle returns the incoming write data.
module register_file #(
    parameter int WIDTH        = 36,
    parameter int REGNUM       = 16,
    parameter int ADDRESSWIDTH = 4
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    writeEnable,
    input  logic [ADDRESSWIDTH-1:0] writeAddress,
    input  logic [WIDTH-1:0]        writeData,
    input  logic [ADDRESSWIDTH-1:0] readAddress1,
    input  logic [ADDRESSWIDTH-1:0] readAddress2,
    output logic [WIDTH-1:0]        readData1,
    output logic [WIDTH-1:0]        readData2
);

    logic [WIDTH-1:0] regs [REGNUM];

    // Reset takes priority over a write arriving in the same cycle.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < REGNUM; i++) begin
                regs[i] <= '0;
            end
        end else if (writeEnable) begin
            regs[writeAddress] <= writeData;
        end
    end

    always_comb begin
        readData1 = regs[readAddress1];
        readData2 = regs[readAddress2];
        if (writeEnable && (writeAddress == readAddress1)) readData1 = writeData;
        if (writeEnable && (writeAddress == readAddress2)) readData2 = writeData;
    end

endmodule

// File: rtl/decode_control_stage.sv
// Decode stage: field split, register read, immediate extension, control
// generation, write-back mux and branch resolution for the execute opcode.
module decode_control_stage
    import isa_pkg::*;
#(
    parameter int WIDTH            = 36,
    parameter int REGNUM           = 16,
    parameter int ADDRESSWIDTH     = 4,
    parameter int OPCODEWIDTH      = 4,
    parameter int INSTRUCTIONWIDTH = 24
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic [INSTRUCTIONWIDTH-1:0] instruction,
    input  logic [WIDTH-1:0]            pcPlus1,
    input  logic                        wbWriteEnable,
    input  logic [ADDRESSWIDTH-1:0]     wbWriteAddress,
    input  logic                        wbResultSelector,
    input  logic [WIDTH-1:0]            wbAluResult,
    input  logic [WIDTH-1:0]            wbMemData,
    output logic [WIDTH-1:0]            wbResult,
    input  logic [OPCODEWIDTH-1:0]      opcodeE,
    input  logic                        flagN,
    input  logic                        flagZ,
    input  logic                        flagV,
    input  logic                        flagC,
    output logic [WIDTH-1:0]            reg1Content,
    output logic [WIDTH-1:0]            reg2Content,
    output logic [WIDTH-1:0]            immediate,
    output logic [ADDRESSWIDTH-1:0]     regDestinationAddress,
    output logic [ADDRESSWIDTH-1:0]     reg1Address,
    output logic [ADDRESSWIDTH-1:0]     reg2Address,
    output logic [OPCODEWIDTH-1:0]      opcode,
    output logic                        writeEnable,
    output logic                        memWriteEnable,
    output logic                        resultSelector,
    output logic                        data2Selector,
    output logic                        outFlagIO,
    output logic [2:0]                  aluControl,
    output logic                        takeBranch
);

    logic [WIDTH-1:0] rfData1;
    logic [WIDTH-1:0] rfData2;
    logic             isBranch;
    logic             unusedFlags;

    // Only Z drives the current branch set; N/V/C are kept on the port for later ops.
    assign unusedFlags = ^{flagN, flagV, flagC};

    assign opcode   = instruction[OPCODE_MSB:OPCODE_LSB];
    assign isBranch = isBranchOp(opcode);
    assign wbResult = wbResultSelector ? wbMemData : wbAluResult;

    always_comb begin
        regDestinationAddress = '0;
        reg1Address           = '0;
        reg2Address           = '0;
        case (opcode)
            OP_ADDI, OP_SHLI, OP_SHRI, OP_LOAD: begin
                regDestinationAddress = instruction[RD_MSB:RD_LSB];
                reg1Address           = instruction[RS1_MSB:RS1_LSB];
            end
            OP_STORE: begin
                reg2Address = instruction[RD_MSB:RD_LSB];
                reg1Address = instruction[RS1_MSB:RS1_LSB];
            end
            OP_BEQ, OP_BNE, OP_B: ;
            default: begin
                regDestinationAddress = instruction[RD_MSB:RD_LSB];
                reg1Address           = instruction[RS1_MSB:RS1_LSB];
                reg2Address           = instruction[RS2_MSB:RS2_LSB];
            end
        endcase
    end

    always_comb begin
        if (isBranch) begin
            immediate = {{(WIDTH-IMM20_MSB-1){instruction[IMM20_MSB]}}, instruction[IMM20_MSB:0]};
        end else begin
            immediate = {{(WIDTH-IMM12_MSB-1){instruction[IMM12_MSB]}}, instruction[IMM12_MSB:0]};
        end
    end

    always_comb begin
        writeEnable    = 1'b0;
        memWriteEnable = 1'b0;
        resultSelector = 1'b0;
        data2Selector  = 1'b0;
        outFlagIO      = 1'b0;
        aluControl     = ALU_ADD;
        case (opcode)
            OP_ADD:  writeEnable = 1'b1;
            OP_SUB:  begin writeEnable = 1'b1; aluControl = ALU_SUB; end
            OP_MUL:  begin writeEnable = 1'b1; aluControl = ALU_MUL; end
            OP_AND:  begin writeEnable = 1'b1; aluControl = ALU_AND; end
            OP_OR:   begin writeEnable = 1'b1; aluControl = ALU_OR;  end
            OP_ADDI: begin writeEnable = 1'b1; data2Selector = 1'b1; end
            OP_SHLI: begin writeEnable = 1'b1; data2Selector = 1'b1; aluControl = ALU_SHL; end
            OP_SHRI: begin writeEnable = 1'b1; data2Selector = 1'b1; aluControl = ALU_SHR; end
            OP_LOAD: begin writeEnable = 1'b1; resultSelector = 1'b1; data2Selector = 1'b1; end
            OP_STORE: begin memWriteEnable = 1'b1; data2Selector = 1'b1; end
            OP_CMP:  aluControl = ALU_SUB;
            OP_BEQ, OP_BNE, OP_B: data2Selector = 1'b1;
            OP_END:  outFlagIO = 1'b1;
            default: ;
        endcase
    end

    always_comb begin
        case (opcodeE)
            OP_BEQ:  takeBranch = flagZ;
            OP_BNE:  takeBranch = !flagZ;
            OP_B:    takeBranch = 1'b1;
            default: takeBranch = 1'b0;
        endcase
    end

    // Branches feed the PC into operand A so the ALU forms pcPlus1 + offset.
    assign reg1Content = isBranch ? pcPlus1 : rfData1;
    assign reg2Content = rfData2;

    register_file #(
        .WIDTH        (WIDTH),
        .REGNUM       (REGNUM),
        .ADDRESSWIDTH (ADDRESSWIDTH)
    ) registerFile (
        .clock        (clock),
        .reset        (reset),
        .writeEnable  (wbWriteEnable),
        .writeAddress (wbWriteAddress),
        .writeData    (wbResult),
        .readAddress1 (reg1Address),
        .readAddress2 (reg2Address),
        .readData1    (rfData1),
        .readData2    (rfData2)
    );

endmodule

// File: tb/tb_decode_control_stage.sv
// Directed bench for decode_control_stage: register file, bypass, field decode,
// control map and branch resolution against hand-computed values.
module tb_decode_control_stage;

    logic        clock = 1'b0;
    logic        reset;
    logic [23:0] instruction;
    logic [35:0] pcPlus1;
    logic        wbWriteEnable;
    logic [3:0]  wbWriteAddress;
    logic        wbResultSelector;
    logic [35:0] wbAluResult;
    logic [35:0] wbMemData;
    logic [35:0] wbResult;
    logic [3:0]  opcodeE;
    logic        flagN, flagZ, flagV, flagC;
    logic [35:0] reg1Content, reg2Content, immediate;
    logic [3:0]  regDestinationAddress, reg1Address, reg2Address, opcode;
    logic        writeEnable, memWriteEnable, resultSelector, data2Selector, outFlagIO;
    logic [2:0]  aluControl;
    logic        takeBranch;

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    decode_control_stage dut (
        .clock(clock), .reset(reset), .instruction(instruction), .pcPlus1(pcPlus1),
        .wbWriteEnable(wbWriteEnable), .wbWriteAddress(wbWriteAddress),
        .wbResultSelector(wbResultSelector), .wbAluResult(wbAluResult),
        .wbMemData(wbMemData), .wbResult(wbResult), .opcodeE(opcodeE),
        .flagN(flagN), .flagZ(flagZ), .flagV(flagV), .flagC(flagC),
        .reg1Content(reg1Content), .reg2Content(reg2Content), .immediate(immediate),
        .regDestinationAddress(regDestinationAddress), .reg1Address(reg1Address),
        .reg2Address(reg2Address), .opcode(opcode), .writeEnable(writeEnable),
        .memWriteEnable(memWriteEnable), .resultSelector(resultSelector),
        .data2Selector(data2Selector), .outFlagIO(outFlagIO),
        .aluControl(aluControl), .takeBranch(takeBranch)
    );

    task automatic test_reset();
        @(negedge clock);
        reset = 1'b1;
        wbWriteEnable = 1'b1; wbWriteAddress = 4'd4; wbResultSelector = 1'b0;
        wbAluResult = 36'h0DEADBEEF;
        @(posedge clock); #1;
        reset = 1'b0; wbWriteEnable = 1'b0;
        instruction = 24'h101200;
        #1;
        checks++; if (reg1Content !== 36'h0) begin errors++; $display("FAIL reset_r1 got %h want 0", reg1Content); end
        checks++; if (reg2Content !== 36'h0) begin errors++; $display("FAIL reset_r2 got %h want 0", reg2Content); end
        instruction = 24'h104400;
        #1;
        checks++; if (reg1Content !== 36'h0) begin errors++; $display("FAIL reset_wins_r4 got %h want 0", reg1Content); end
    endtask

    task automatic test_write_read();
        @(negedge clock);
        wbWriteEnable = 1'b1; wbWriteAddress = 4'd3; wbResultSelector = 1'b0;
        wbAluResult = 36'h123456789; wbMemData = 36'h111111111;
        #1;
        checks++; if (wbResult !== 36'h123456789) begin errors++; $display("FAIL wb_mux_alu got %h want 123456789", wbResult); end
        @(posedge clock); #1;
        wbWriteEnable = 1'b0; wbAluResult = 36'h0;
        instruction = 24'h113300;
        #1;
        checks++; if (reg1Content !== 36'h123456789) begin errors++; $display("FAIL write_r3_rs1 got %h want 123456789", reg1Content); end
        checks++; if (reg2Content !== 36'h123456789) begin errors++; $display("FAIL write_r3_rs2 got %h want 123456789", reg2Content); end
        checks++; if (regDestinationAddress !== 4'd1) begin errors++; $display("FAIL add_rd got %h want 1", regDestinationAddress); end
    endtask

    task automatic test_bypass();
        @(negedge clock);
        wbWriteEnable = 1'b1; wbWriteAddress = 4'd5; wbResultSelector = 1'b1;
        wbMemData = 36'hABC; wbAluResult = 36'h555;
        instruction = 24'h105000;
        #1;
        checks++; if (reg1Content !== 36'hABC) begin errors++; $display("FAIL bypass_r5 got %h want abc", reg1Content); end
        checks++; if (wbResult !== 36'hABC) begin errors++; $display("FAIL wb_mux_mem got %h want abc", wbResult); end
        checks++; if (reg2Content !== 36'h0) begin errors++; $display("FAIL bypass_r0_untouched got %h want 0", reg2Content); end
        @(posedge clock); #1;
        wbWriteEnable = 1'b0; wbMemData = 36'h0;
        #1;
        checks++; if (reg1Content !== 36'hABC) begin errors++; $display("FAIL stored_r5 got %h want abc", reg1Content); end
        @(negedge clock);
        wbWriteEnable = 1'b1; wbWriteAddress = 4'd15; wbResultSelector = 1'b0;
        wbAluResult = 36'hFEDCBA987;
        instruction = 24'h105F00;
        #1;
        checks++; if (reg2Content !== 36'hFEDCBA987) begin errors++; $display("FAIL bypass_r15_port2 got %h want fedcba987", reg2Content); end
        @(posedge clock); #1;
        wbWriteEnable = 1'b0; wbAluResult = 36'h0;
        #1;
        checks++; if (reg2Content !== 36'hFEDCBA987) begin errors++; $display("FAIL stored_r15 got %h want fedcba987", reg2Content); end
        checks++; if (reg1Content !== 36'hABC) begin errors++; $display("FAIL r5_kept got %h want abc", reg1Content); end
    endtask

    task automatic test_load_store();
        instruction = 24'h921FFF;
        #1;
        checks++; if (writeEnable !== 1'b1) begin errors++; $display("FAIL load_we got %b want 1", writeEnable); end
        checks++; if (resultSelector !== 1'b1) begin errors++; $display("FAIL load_rsel got %b want 1", resultSelector); end
        checks++; if (data2Selector !== 1'b1) begin errors++; $display("FAIL load_d2sel got %b want 1", data2Selector); end
        checks++; if (aluControl !== 3'b000) begin errors++; $display("FAIL load_alu got %b want 000", aluControl); end
        checks++; if (immediate !== 36'hFFFFFFFFF) begin errors++; $display("FAIL load_imm got %h want fffffffff", immediate); end
        checks++; if (regDestinationAddress !== 4'd2 || reg1Address !== 4'd1) begin
            errors++; $display("FAIL load_addr got rd=%h rs1=%h want rd=2 rs1=1", regDestinationAddress, reg1Address); end
        instruction = 24'hA74010;
        #1;
        checks++; if (memWriteEnable !== 1'b1) begin errors++; $display("FAIL store_mwe got %b want 1", memWriteEnable); end
        checks++; if (writeEnable !== 1'b0) begin errors++; $display("FAIL store_we got %b want 0", writeEnable); end
        checks++; if (reg2Address !== 4'd7) begin errors++; $display("FAIL store_rs2 got %h want 7", reg2Address); end
        checks++; if (reg1Address !== 4'd4) begin errors++; $display("FAIL store_rs1 got %h want 4", reg1Address); end
        checks++; if (immediate !== 36'h10) begin errors++; $display("FAIL store_imm got %h want 10", immediate); end
        instruction = 24'h6127FF;
        #1;
        checks++; if (immediate !== 36'h7FF) begin errors++; $display("FAIL addi_imm_pos got %h want 7ff", immediate); end
        instruction = 24'h1ABC00;
        #1;
        checks++; if (regDestinationAddress !== 4'hA || reg1Address !== 4'hB || reg2Address !== 4'hC) begin
            errors++; $display("FAIL rtype_addr got %h %h %h want a b c", regDestinationAddress, reg1Address, reg2Address); end
    endtask

    task automatic test_control_map();
        logic [2:0] expAlu [16];
        logic [15:0] expWe, expD2, expRs, expMwe, expIo;
        logic [23:0] instr;
        expAlu = '{3'd0, 3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd0, 3'd5,
                   3'd6, 3'd0, 3'd0, 3'd1, 3'd0, 3'd0, 3'd0, 3'd0};
        // bit n = expected value for opcode n
        expWe  = 16'b0000_0011_1111_1110;
        expD2  = 16'b0111_0111_1100_0000;
        expRs  = 16'b0000_0010_0000_0000;
        expMwe = 16'b0000_0100_0000_0000;
        expIo  = 16'b1000_0000_0000_0000;
        for (int op = 0; op < 16; op++) begin
            instr = {op[3:0], 20'h12345};
            instruction = instr;
            #1;
            checks++;
            if (opcode !== op[3:0] || aluControl !== expAlu[op] || writeEnable !== expWe[op] ||
                data2Selector !== expD2[op] || resultSelector !== expRs[op] ||
                memWriteEnable !== expMwe[op] || outFlagIO !== expIo[op]) begin
                errors++;
                $display("FAIL ctrl_op%0h got op=%h alu=%b we=%b d2=%b rs=%b mwe=%b io=%b want op=%h alu=%b we=%b d2=%b rs=%b mwe=%b io=%b",
                         op, opcode, aluControl, writeEnable, data2Selector, resultSelector, memWriteEnable, outFlagIO,
                         op[3:0], expAlu[op], expWe[op], expD2[op], expRs[op], expMwe[op], expIo[op]);
            end
        end
    endtask

    task automatic test_branch_resolve();
        logic [3:0] opTab [7];
        logic       zTab  [7];
        logic       expTab[7];
        opTab  = '{4'hC, 4'hC, 4'hD, 4'hD, 4'hE, 4'hB, 4'h1};
        zTab   = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
        expTab = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
        flagN = 1'b1; flagV = 1'b1; flagC = 1'b1;
        for (int i = 0; i < 7; i++) begin
            opcodeE = opTab[i]; flagZ = zTab[i];
            #1;
            checks++;
            if (takeBranch !== expTab[i]) begin
                errors++;
                $display("FAIL branch_resolve op=%h z=%b got %b want %b", opTab[i], zTab[i], takeBranch, expTab[i]);
            end
        end
        flagN = 1'b0; flagV = 1'b0; flagC = 1'b0; opcodeE = 4'h0; flagZ = 1'b0;
    endtask

    task automatic test_branch_decode();
        pcPlus1 = 36'h20;
        instruction = 24'hCFFFFE;
        #1;
        checks++; if (reg1Content !== 36'h20) begin errors++; $display("FAIL beq_pc_operand got %h want 20", reg1Content); end
        checks++; if (immediate !== 36'hFFFFFFFFE) begin errors++; $display("FAIL beq_imm got %h want ffffffffe", immediate); end
        checks++; if (reg1Address !== 4'd0 || reg2Address !== 4'd0 || regDestinationAddress !== 4'd0) begin
            errors++; $display("FAIL beq_addr got %h %h %h want 0 0 0", regDestinationAddress, reg1Address, reg2Address); end
        instruction = 24'hE7FFFF;
        #1;
        checks++; if (immediate !== 36'h00007FFFF) begin errors++; $display("FAIL b_imm_pos got %h want 7ffff", immediate); end
        instruction = 24'h105000;
        #1;
        checks++; if (reg1Content !== 36'hABC) begin errors++; $display("FAIL nonbranch_reg_operand got %h want abc", reg1Content); end
    endtask

    initial begin
        reset = 1'b0; instruction = 24'h0; pcPlus1 = 36'h0;
        wbWriteEnable = 1'b0; wbWriteAddress = 4'h0; wbResultSelector = 1'b0;
        wbAluResult = 36'h0; wbMemData = 36'h0;
        opcodeE = 4'h0; flagN = 1'b0; flagZ = 1'b0; flagV = 1'b0; flagC = 1'b0;
        test_reset();
        test_write_read();
        test_bypass();
        test_load_store();
        test_control_map();
        test_branch_resolve();
        test_branch_decode();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
